// File: rtl/dmem_bridge.sv
// Data-memory bridge between the core DMem port and a single-port sync SRAM.
// Stores become byte-lane writes, loads wait out the SRAM read latency.
module dmem_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          SRAM_AW    = 14,
  parameter int          RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        dmem_addr,
  input  logic               dmem_r_enable,
  input  logic               dmem_w_enable,
  input  logic [1:0]         dmem_w_size,
  input  logic [31:0]        dmem_w_data,
  output logic [31:0]        dmem_r_data,
  output logic               dmem_ready,
  output logic               dmem_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_cs,
  output logic               sram_we,
  output logic [3:0]         sram_be,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata
);

  typedef enum logic [1:0] {
    IDLE, ACCESS, WAIT, RESP
  } state_t;

  state_t state, state_d;

  logic               wr_q, wr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        r_data_d;
  logic               ready_d, err_d;
  logic               cs_d, we_d;
  logic [3:0]         be_d;
  logic [SRAM_AW-1:0] addr_d;
  logic [31:0]        wdata_d;

  logic [31:0] offset;
  logic [29:0] word;
  logic        req, oor, misal, bad_size, rej;

  assign req      = dmem_r_enable | dmem_w_enable;
  assign offset   = dmem_addr - BASE_ADDR;
  assign word     = offset[31:2];
  assign oor      = (word >> SRAM_AW) != 30'd0;
  assign bad_size = dmem_w_enable & (dmem_w_size == 2'd3);
  // Loads fetch the aligned word, so only stores can be misaligned
  assign misal    = dmem_w_enable &
                    (((dmem_w_size == 2'd1) & dmem_addr[0]) |
                     ((dmem_w_size == 2'd2) & (dmem_addr[1:0] != 2'b00)));
  assign rej      = oor | misal | bad_size;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (req) state_d = rej ? RESP : ACCESS;
      ACCESS:  state_d = wr_q ? RESP : WAIT;
      WAIT:    if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_data_d = dmem_r_data;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    cs_d     = 1'b0;
    we_d     = 1'b0;
    be_d     = sram_be;
    addr_d   = sram_addr;
    wdata_d  = sram_wdata;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    unique case (state)
      IDLE: begin
        if (req) begin
          wr_d = dmem_w_enable;
          if (rej) begin
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else begin
            cs_d   = 1'b1;
            we_d   = dmem_w_enable;
            addr_d = word[SRAM_AW-1:0];
            be_d   = 4'b1111;
            if (dmem_w_enable) begin
              case (dmem_w_size)
                2'd0: begin
                  be_d    = 4'b0001 << dmem_addr[1:0];
                  wdata_d = {4{dmem_w_data[7:0]}};
                end
                2'd1: begin
                  be_d    = dmem_addr[1] ? 4'b1100 : 4'b0011;
                  wdata_d = {2{dmem_w_data[15:0]}};
                end
                default: wdata_d = dmem_w_data;
              endcase
            end
          end
        end
      end
      ACCESS: begin
        if (wr_q) ready_d = 1'b1;
        else      cnt_d   = 4'(RD_LATENCY - 1);
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          r_data_d = sram_rdata;
          ready_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_r_data <= '0;
      dmem_ready  <= 1'b0;
      dmem_err    <= 1'b0;
      sram_cs     <= 1'b0;
      sram_we     <= 1'b0;
      sram_be     <= '0;
      sram_addr   <= '0;
      sram_wdata  <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dmem_r_data <= r_data_d;
      dmem_ready  <= ready_d;
      dmem_err    <= err_d;
      sram_cs     <= cs_d;
      sram_we     <= we_d;
      sram_be     <= be_d;
      sram_addr   <= addr_d;
      sram_wdata  <= wdata_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: one DUT at RD_LATENCY=1, one at 3,
// sharing request inputs, each backed by a small SRAM model.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        r_en, w_en;
  logic [1:0]  w_size;
  logic [31:0] w_data;

  logic [31:0] r_data0, wdata0, rdata0;
  logic        ready0, err0, cs0, we0;
  logic [3:0]  be0;
  logic [13:0] saddr0;

  logic [31:0] r_data3, wdata3, rdata3;
  logic        ready3, err3, cs3, we3;
  logic [3:0]  be3;
  logic [13:0] saddr3;

  int checks = 0;
  int errors = 0;
  int cs0_cnt = 0;
  int cs3_cnt = 0;
  int rdy3_cnt = 0;
  int cs_base, rdy_base;

  always #5 clk = ~clk;

  dmem_bridge u_dut0 (
    .clk(clk), .reset(reset), .dmem_addr(addr),
    .dmem_r_enable(r_en), .dmem_w_enable(w_en),
    .dmem_w_size(w_size), .dmem_w_data(w_data),
    .dmem_r_data(r_data0), .dmem_ready(ready0), .dmem_err(err0),
    .sram_addr(saddr0), .sram_cs(cs0), .sram_we(we0),
    .sram_be(be0), .sram_wdata(wdata0), .sram_rdata(rdata0)
  );

  dmem_bridge #(.RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .dmem_addr(addr),
    .dmem_r_enable(r_en), .dmem_w_enable(w_en),
    .dmem_w_size(w_size), .dmem_w_data(w_data),
    .dmem_r_data(r_data3), .dmem_ready(ready3), .dmem_err(err3),
    .sram_addr(saddr3), .sram_cs(cs3), .sram_we(we3),
    .sram_be(be3), .sram_wdata(wdata3), .sram_rdata(rdata3)
  );

  logic [31:0] mem0 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p3 [0:2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] = '0;
      mem3[i] = '0;
    end
    rdata0 = '0;
    for (int i = 0; i < 3; i++) p3[i] = '0;
  end

  always @(posedge clk) begin
    if (cs0 && we0)
      for (int i = 0; i < 4; i++)
        if (be0[i]) mem0[saddr0[7:0]][8*i+:8] <= wdata0[8*i+:8];
    if (cs0 && !we0) rdata0 <= mem0[saddr0[7:0]];
  end

  always @(posedge clk) begin
    if (cs3 && we3)
      for (int i = 0; i < 4; i++)
        if (be3[i]) mem3[saddr3[7:0]][8*i+:8] <= wdata3[8*i+:8];
    if (cs3 && !we3) p3[0] <= mem3[saddr3[7:0]];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign rdata3 = p3[2];

  always @(negedge clk) begin
    if (cs0) cs0_cnt++;
    if (cs3) cs3_cnt++;
    if (ready3) rdy3_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; addr = '0; r_en = 0; w_en = 0;
    w_size = '0; w_data = '0;
    step(2);
    chk("rst_cs", 32'(cs0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_rdata", r_data0, 32'd0);
    chk("rst_be", 32'(be3), 32'd0);
    reset = 1'b1;
    cs_base = cs0_cnt;
    step(3);
    chk("idle_cs", 32'(cs0_cnt - cs_base), 32'd0);
    chk("idle_ready", 32'(ready0), 32'd0);

    addr = 32'h10; w_size = 2'd2; w_data = 32'hDEADBEEF; w_en = 1;
    step(1);
    chk("sw_cs", 32'(cs0), 32'd1);
    chk("sw_we", 32'(we0), 32'd1);
    chk("sw_addr", 32'(saddr0), 32'd4);
    chk("sw_be", 32'(be0), 32'hF);
    chk("sw_wdata", wdata0, 32'hDEADBEEF);
    chk("sw_rdy_early", 32'(ready0), 32'd0);
    step(1);
    chk("sw_ready", 32'(ready0), 32'd1);
    chk("sw_err", 32'(err0), 32'd0);
    chk("sw_cs_off", 32'(cs0), 32'd0);
    w_en = 0;
    step(4);

    r_en = 1;
    step(1);
    chk("lw_cs", 32'(cs0), 32'd1);
    chk("lw_we", 32'(we0), 32'd0);
    chk("lw_be", 32'(be0), 32'hF);
    step(1);
    chk("lw_rdy_early", 32'(ready0), 32'd0);
    step(1);
    chk("lw_ready", 32'(ready0), 32'd1);
    chk("lw_data", r_data0, 32'hDEADBEEF);
    r_en = 0;
    step(4);

    addr = 32'h13; w_size = 2'd0; w_data = 32'h0000_00AB; w_en = 1;
    step(1);
    chk("sb_be", 32'(be0), 32'h8);
    chk("sb_wdata", wdata0, 32'hABABABAB);
    chk("sb_addr", 32'(saddr0), 32'd4);
    step(1);
    chk("sb_ready", 32'(ready0), 32'd1);
    w_en = 0;
    step(4);

    addr = 32'h12; w_size = 2'd1; w_data = 32'h0000_1234; w_en = 1;
    step(1);
    chk("sh_be", 32'(be0), 32'hC);
    chk("sh_wdata", wdata0, 32'h12341234);
    step(1);
    chk("sh_ready", 32'(ready0), 32'd1);
    w_en = 0;
    step(4);

    addr = 32'h10; r_en = 1;
    step(3);
    chk("lw2_ready", 32'(ready0), 32'd1);
    chk("lw2_data", r_data0, 32'h1234BEEF);
    r_en = 0;
    step(4);

    cs_base = cs0_cnt;
    addr = 32'h11; w_size = 2'd1; w_en = 1;
    step(1);
    chk("mis_ready", 32'(ready0), 32'd1);
    chk("mis_err", 32'(err0), 32'd1);
    chk("mis_rdata", r_data0, 32'h1234BEEF);
    w_en = 0;
    step(1);
    chk("mis_rdy_off", 32'(ready0), 32'd0);
    chk("mis_no_cs", 32'(cs0_cnt - cs_base), 32'd0);
    step(3);

    addr = 32'h0001_0000; r_en = 1;
    step(1);
    chk("oor_ready", 32'(ready0), 32'd1);
    chk("oor_err", 32'(err0), 32'd1);
    r_en = 0;
    step(4);

    addr = 32'h20; w_size = 2'd3; w_en = 1;
    step(1);
    chk("sz3_ready", 32'(ready0), 32'd1);
    chk("sz3_err", 32'(err0), 32'd1);
    w_en = 0;
    step(4);

    cs_base = cs0_cnt;
    addr = 32'h20; w_size = 2'd2; w_data = 32'h55AA55AA;
    w_en = 1; r_en = 1;
    step(1);
    chk("both_cs", 32'(cs0), 32'd1);
    chk("both_we", 32'(we0), 32'd1);
    step(1);
    chk("both_ready", 32'(ready0), 32'd1);
    chk("both_err", 32'(err0), 32'd0);
    w_en = 0; r_en = 0;
    step(4);
    chk("both_one_cs", 32'(cs0_cnt - cs_base), 32'd1);

    addr = 32'h14; w_size = 2'd2; w_data = 32'hCAFEF00D; w_en = 1;
    step(2);
    w_en = 0;
    step(4);

    cs_base = cs3_cnt;
    addr = 32'h10; r_en = 1;
    step(1);
    chk("l3a_cs", 32'(cs3), 32'd1);
    step(3);
    chk("l3a_rdy_early", 32'(ready3), 32'd0);
    step(1);
    chk("l3a_ready", 32'(ready3), 32'd1);
    chk("l3a_data", r_data3, 32'h1234BEEF);
    addr = 32'h14;
    step(5);
    chk("l3b_rdy_early", 32'(ready3), 32'd0);
    step(1);
    chk("l3b_ready", 32'(ready3), 32'd1);
    chk("l3b_data", r_data3, 32'hCAFEF00D);
    r_en = 0;
    step(4);
    chk("l3_two_cs", 32'(cs3_cnt - cs_base), 32'd2);

    rdy_base = rdy3_cnt;
    addr = 32'h20; r_en = 1;
    step(2);
    reset = 1'b0;
    #1;
    chk("rw_rdata3", r_data3, 32'd0);
    chk("rw_be3", 32'(be3), 32'd0);
    chk("rw_addr3", 32'(saddr3), 32'd0);
    chk("rw_rdata0", r_data0, 32'd0);
    chk("rw_ready3", 32'(ready3), 32'd0);
    r_en = 0;
    step(2);
    reset = 1'b1;
    step(6);
    chk("rw_no_pulse", 32'(rdy3_cnt - rdy_base), 32'd0);

    addr = 32'h20; r_en = 1;
    step(5);
    chk("rw_fresh_ready", 32'(ready3), 32'd1);
    chk("rw_fresh_data", r_data3, 32'h55AA55AA);
    r_en = 0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
